// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl: in-order issue controller for a single-issue execution pipeline.
//
// A DEPTH-entry instruction FIFO feeds the pipeline one instruction per cycle.
// A WB_LAT-deep scoreboard of in-flight destination registers stalls the queue
// head while any source register it reads has a write still in flight.
// Heads with an undefined func (> 4'b1011) are discarded in one cycle, and a
// one-cycle illegal pulse follows.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_instr    host push: {func[23:20], rs1, rs2, rd, addr[7:0]}
//   in_ready              queue not full
//   issue_valid           registered issue strobe
//   rs1, rs2, rd, func    registered instruction fields; hold their last issued values
//   addr                  registered data-memory address
//   illegal               one-cycle pulse after an undefined instruction is discarded
//   busy                  queue non-empty or any scoreboard entry valid
//   issue_cnt, stall_cnt  (ISSUE_STATS_EN only) issue and hazard-stall counters, wrapping
//
// Optional feature: define ISSUE_STATS_EN to add the statistics counters.

module pipe_issue_ctrl #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WB_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [23:0] in_instr,
    output logic        in_ready,
    output logic        issue_valid,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd,
    output logic [3:0]  func,
    output logic [7:0]  addr,
    output logic        illegal,
    output logic        busy
`ifdef ISSUE_STATS_EN
    ,
    output logic [15:0] issue_cnt,
    output logic [15:0] stall_cnt
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [3:0]  FUNC_MAX = 4'b1011;

    typedef struct packed {
        logic [3:0] func;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [7:0] addr;
    } instr_t;

    // Instruction queue storage and pointers
    instr_t             q_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    // Scoreboard of in-flight destination registers; index 0 is the newest
    logic [WB_LAT-1:0]  sb_valid;
    logic [3:0]         sb_rd [WB_LAT];

    instr_t             head;
    logic               q_empty;
    logic               q_full;
    logic               push_c;
    logic               pop_c;
    logic               use_rs1_c;
    logic               use_rs2_c;
    logic               hazard_c;
    logic               head_illegal_c;
    logic               issue_c;
    logic               discard_c;
    logic               stall_c;

    assign q_empty  = (count == '0);
    assign q_full   = (count == CNT_W'(DEPTH));
    assign in_ready = ~q_full;
    assign busy     = ~q_empty | (|sb_valid);
    assign head     = q_mem[rd_ptr];

    assign push_c   = in_valid & ~q_full;

    // Source operand usage by func class
    always_comb begin
        use_rs1_c = 1'b0;
        use_rs2_c = 1'b0;
        case (head.func)
            4'b0000, 4'b0001, 4'b0010,
            4'b0011, 4'b0100, 4'b0101: begin
                use_rs1_c = 1'b1;
                use_rs2_c = 1'b1;
            end
            4'b0110, 4'b1000, 4'b1010: use_rs1_c = 1'b1;
            4'b0111, 4'b1001, 4'b1011: use_rs2_c = 1'b1;
            default: begin
                use_rs1_c = 1'b0;
                use_rs2_c = 1'b0;
            end
        endcase
    end

    // RAW hazard against any valid in-flight destination; WAW is ignored
    always_comb begin
        hazard_c = 1'b0;
        for (int unsigned i = 0; i < WB_LAT; i++) begin
            if (sb_valid[i] &&
                ((use_rs1_c && (sb_rd[i] == head.rs1)) ||
                 (use_rs2_c && (sb_rd[i] == head.rs2)))) begin
                hazard_c = 1'b1;
            end
        end
    end

    // Head disposition: discard undefined, issue if clear, otherwise stall
    assign head_illegal_c = (head.func > FUNC_MAX);
    assign discard_c      = ~q_empty & head_illegal_c;
    assign issue_c        = ~q_empty & ~head_illegal_c & ~hazard_c;
    assign stall_c        = ~q_empty & ~head_illegal_c &  hazard_c;
    assign pop_c          = discard_c | issue_c;

    // Queue storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push_c) begin
            q_mem[wr_ptr] <= instr_t'(in_instr);
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Scoreboard shifts every cycle; only real issues enter as valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid <= '0;
            for (int unsigned i = 0; i < WB_LAT; i++) begin
                sb_rd[i] <= 4'h0;
            end
        end else begin
            sb_valid[0] <= issue_c;
            sb_rd[0]    <= head.rd;
            for (int unsigned i = 1; i < WB_LAT; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
        end
    end

    // Registered issue outputs; fields hold when nothing issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid <= 1'b0;
            illegal     <= 1'b0;
            func        <= 4'h0;
            rs1         <= 4'h0;
            rs2         <= 4'h0;
            rd          <= 4'h0;
            addr        <= 8'h00;
        end else begin
            issue_valid <= issue_c;
            illegal     <= discard_c;
            if (issue_c) begin
                func <= head.func;
                rs1  <= head.rs1;
                rs2  <= head.rs2;
                rd   <= head.rd;
                addr <= head.addr;
            end
        end
    end

`ifdef ISSUE_STATS_EN
    // Issue and hazard-stall counters; empty cycles are not stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= 16'h0000;
            stall_cnt <= 16'h0000;
        end else begin
            if (issue_c) begin
                issue_cnt <= issue_cnt + 16'h0001;
            end
            if (stall_c) begin
                stall_cnt <= stall_cnt + 16'h0001;
            end
        end
    end
`else
    // stall_c only feeds the statistics counters
    logic unused_stall;
    assign unused_stall = stall_c;
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Testbench for pipe_issue_ctrl: scoreboard of expected issued instructions,
// plus issue-timing checks for hazards, discards, back-pressure and reset.

module tb_pipe_issue_ctrl;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned WB_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_instr = 24'h0;
    logic        in_ready;
    logic        issue_valid;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        illegal;
    logic        busy;
`ifdef ISSUE_STATS_EN
    logic [15:0] issue_cnt;
    logic [15:0] stall_cnt;
    logic [15:0] stall_base;
`endif

    pipe_issue_ctrl #(.DEPTH(DEPTH), .WB_LAT(WB_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .issue_valid (issue_valid),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .func        (func),
        .addr        (addr),
        .illegal     (illegal),
        .busy        (busy)
`ifdef ISSUE_STATS_EN
        ,
        .issue_cnt   (issue_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errs    = 0;
    int          cyc     = 0;
    logic [23:0] expq [$];
    int          issue_t [$];
    int          illegal_t [$];
    logic [23:0] exp_w;
    logic        last_acc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: every issue is matched against the expected queue
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (issue_valid) begin
                issue_t.push_back(cyc);
                if (expq.size() == 0) begin
                    check_val("unexpected_issue", {8'h0, func, rs1, rs2, rd, addr}, 32'hFFFF_FFFF);
                end else begin
                    exp_w = expq.pop_front();
                    check_val("issue_fields", {8'h0, func, rs1, rs2, rd, addr}, {8'h0, exp_w});
                end
            end
            if (illegal) begin
                illegal_t.push_back(cyc);
            end
        end
    end

    // Present one instruction for one edge; undefined funcs are never expected to issue
    task automatic push(input logic [3:0] f, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d, input logic [7:0] a);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = {f, s1, s2, d, a};
        last_acc = in_ready;
        if (last_acc && (f <= 4'hB)) begin
            expq.push_back({f, s1, s2, d, a});
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_val("drain", {31'h0, (expq.size() == 0 && !busy)}, 32'h1);
    endtask

    task automatic clear_logs();
        issue_t.delete();
        illegal_t.delete();
    endtask

    initial begin
        // Reset state
        #1;
        check_val("rst_ready", {31'h0, in_ready}, 32'h1);
        check_val("rst_busy", {31'h0, busy}, 32'h0);
        check_val("rst_issue", {31'h0, issue_valid}, 32'h0);
        check_val("rst_fields", {8'h0, func, rs1, rs2, rd, addr}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`ifdef ISSUE_STATS_EN
        check_val("rst_issue_cnt", {16'h0, issue_cnt}, 32'h0);
`endif

        // Independent ADD then XOR issue back-to-back
        clear_logs();
        push(4'h0, 4'h2, 4'h3, 4'h1, 8'h10);
        push(4'h4, 4'h5, 4'h6, 4'h4, 8'h11);
        idle();
        drain();
        check_val("indep_cnt", issue_t.size(), 2);
        check_val("indep_gap", issue_t[1] - issue_t[0], 1);

        // RAW: SUB reading r1 waits WB_LAT+1 cycles after the ADD writing r1
        clear_logs();
`ifdef ISSUE_STATS_EN
        stall_base = stall_cnt;
`endif
        push(4'h0, 4'h2, 4'h3, 4'h1, 8'h20);
        push(4'h1, 4'h1, 4'h7, 4'h8, 8'h21);
        idle();
        drain();
        check_val("raw_cnt", issue_t.size(), 2);
        check_val("raw_gap", issue_t[1] - issue_t[0], WB_LAT + 1);
`ifdef ISSUE_STATS_EN
        check_val("raw_stall_cnt", {16'h0, stall_cnt - stall_base}, WB_LAT);
`endif

        // func 0111 reads rs2 only: rs1 match does not stall
        clear_logs();
        push(4'h0, 4'h2, 4'h3, 4'h5, 8'h30);
        push(4'h7, 4'h5, 4'h9, 4'hA, 8'h31);
        idle();
        drain();
        check_val("rs2only_nostall", issue_t[1] - issue_t[0], 1);

        // func 0111 with rs2 matching an in-flight rd stalls
        clear_logs();
        push(4'h0, 4'h2, 4'h3, 4'h6, 8'h40);
        push(4'h7, 4'h0, 4'h6, 4'hB, 8'h41);
        idle();
        drain();
        check_val("rs2only_stall", issue_t[1] - issue_t[0], WB_LAT + 1);

        // WAW alone does not stall
        clear_logs();
        push(4'h0, 4'h2, 4'h4, 4'h3, 8'h50);
        push(4'h0, 4'h8, 4'h9, 4'h3, 8'h51);
        idle();
        drain();
        check_val("waw_gap", issue_t[1] - issue_t[0], 1);

        // Undefined func is discarded; following ADD issues the next cycle
        clear_logs();
        push(4'hC, 4'h1, 4'h1, 4'h1, 8'h60);
        push(4'h0, 4'hD, 4'hE, 4'h9, 8'h61);
        idle();
        drain();
        check_val("illegal_pulses", illegal_t.size(), 1);
        check_val("illegal_issue_cnt", issue_t.size(), 1);
        check_val("illegal_then_add", issue_t[0] - illegal_t[0], 1);
        check_val("hold_fields", {8'h0, func, rs1, rs2, rd, addr}, {8'h0, 4'h0, 4'hD, 4'hE, 4'h9, 8'h61});

        // Fill the queue behind a stalled head; extra push is refused
        clear_logs();
        push(4'h0, 4'h3, 4'h4, 4'h2, 8'h70);
        push(4'h0, 4'h2, 4'h0, 4'hA, 8'h71);
        push(4'h2, 4'h0, 4'h1, 4'hB, 8'h72);
        push(4'h3, 4'h1, 4'h0, 4'hC, 8'h73);
        push(4'h5, 4'h0, 4'h0, 4'hD, 8'h74);
        push(4'h0, 4'h0, 4'h1, 4'hF, 8'h75);
        check_val("full_ready", {31'h0, in_ready}, 32'h0);
        check_val("full_refused", {31'h0, last_acc}, 32'h0);
        idle();
        drain();
        check_val("full_cnt", issue_t.size(), 5);
        check_val("full_gap0", issue_t[1] - issue_t[0], WB_LAT + 1);
        check_val("full_gap1", issue_t[2] - issue_t[1], 1);
        check_val("full_gap2", issue_t[3] - issue_t[2], 1);
        check_val("full_gap3", issue_t[4] - issue_t[3], 1);

        // Reset while full with a hazard pending
        clear_logs();
        push(4'h0, 4'h3, 4'h4, 4'h2, 8'h80);
        push(4'h0, 4'h2, 4'h0, 4'hA, 8'h81);
        push(4'h2, 4'h0, 4'h1, 4'hB, 8'h82);
        push(4'h3, 4'h1, 4'h0, 4'hC, 8'h83);
        push(4'h5, 4'h0, 4'h0, 4'hD, 8'h84);
        idle();
        check_val("pre_rst_full", {31'h0, in_ready}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        expq.delete();
        check_val("mid_rst_issue", {31'h0, issue_valid}, 32'h0);
        check_val("mid_rst_busy", {31'h0, busy}, 32'h0);
        check_val("mid_rst_ready", {31'h0, in_ready}, 32'h1);
        check_val("mid_rst_fields", {8'h0, func, rs1, rs2, rd, addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        // Second instruction reads r2, which was in flight before reset
        push(4'h0, 4'h1, 4'h2, 4'h7, 8'h90);
        push(4'h1, 4'h2, 4'h3, 4'h8, 8'h91);
        idle();
        drain();
        check_val("post_rst_cnt", issue_t.size(), 2);
        check_val("post_rst_gap", issue_t[1] - issue_t[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
